cal_rii: RTL and testbench

CAL_RII -- requirements
Module: cal_rii

---
 rtl/cal_rii_if.sv | 34 +++
 rtl/cal_rii.sv | 130 +++++++++++++
 tb/tb_cal_rii.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cal_rii_if.sv
// Column handshake and result bus for the cal_rii column-norm stage.
// The master side presents columns; the slave side (cal_rii) returns the norm.
interface cal_rii_if;
  logic         i_valid;
  logic [191:0] i_h_column;
  logic         o_ready;
  logic [191:0] o_h_column;
  logic [19:0]  o_Rii;
  logic         o_div_en;
  logic         o_zero;
  logic         o_sat;

  modport master (
    output i_valid,
    output i_h_column,
    input  o_ready,
    input  o_h_column,
    input  o_Rii,
    input  o_div_en,
    input  o_zero,
    input  o_sat
  );

  modport slave (
    input  i_valid,
    input  i_h_column,
    output o_ready,
    output o_h_column,
    output o_Rii,
    output o_div_en,
    output o_zero,
    output o_sat
  );
endinterface

// File: rtl/cal_rii.sv
// Column norm: sums the squares of eight S7.16 elements, then takes a
// truncating restoring square root, clamped to 19 magnitude bits.
module cal_rii (
  input logic      i_clk,
  input logic      i_rst_n,
  cal_rii_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC, CHK, SQRT, OUT} state_t;

  localparam logic [4:0]  LastElem = 5'd7;
  localparam logic [4:0]  LastBit  = 5'd18;
  localparam logic [19:0] RiiMax   = 20'h7FFFF;

  state_t         state_q;
  logic [191:0]   col_q;
  logic [49:0]    acc_q;
  logic [4:0]     idx_q;
  logic [19:0]    rem_q;
  logic [18:0]    root_q;
  logic           sat_q;
  logic           zero_q;
  logic [191:0]   outCol_q;
  logic [19:0]    outRii_q;
  logic           divEn_q;
  logic           outZero_q;
  logic           outSat_q;

  logic signed [23:0] elem;
  logic signed [47:0] square;
  logic [49:0]        acc_d;
  logic [21:0]        remShift;
  logic [21:0]        trial;
  logic [19:0]        rem_d;
  logic [18:0]        root_d;

  // One element square per ACC cycle; one root bit per SQRT cycle. During
  // SQRT the accumulator doubles as the radicand shift register.
  always_comb begin
    elem     = col_q[32'(idx_q[2:0]) * 24 +: 24];
    square   = elem * elem;
    acc_d    = acc_q + {2'b00, square};
    remShift = {rem_q, acc_q[37:36]};
    trial    = {1'b0, root_q, 2'b01};
    rem_d    = remShift[19:0];
    root_d   = {root_q[17:0], 1'b0};
    if (remShift >= trial) begin
      rem_d  = 20'(remShift - trial);
      root_d = {root_q[17:0], 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      sat_q     <= 1'b0;
      zero_q    <= 1'b0;
      outCol_q  <= '0;
      outRii_q  <= '0;
      divEn_q   <= 1'b0;
      outZero_q <= 1'b0;
      outSat_q  <= 1'b0;
    end else begin
      divEn_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            col_q   <= bus.i_h_column;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          if (idx_q == LastElem) begin
            idx_q   <= '0;
            state_q <= CHK;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        CHK: begin
          // Anything at or above 2^38 has a root that no longer fits 19 bits.
          sat_q   <= |acc_q[49:38];
          zero_q  <= (acc_q == '0);
          rem_q   <= '0;
          root_q  <= '0;
          idx_q   <= '0;
          state_q <= SQRT;
        end
        SQRT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          acc_q  <= {acc_q[47:0], 2'b00};
          if (idx_q == LastBit) begin
            idx_q     <= '0;
            outCol_q  <= col_q;
            outRii_q  <= sat_q ? RiiMax : {1'b0, root_d};
            outZero_q <= zero_q;
            outSat_q  <= sat_q;
            divEn_q   <= 1'b1;
            state_q   <= OUT;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_h_column = outCol_q;
  assign bus.o_Rii      = outRii_q;
  assign bus.o_div_en   = divEn_q;
  assign bus.o_zero     = outZero_q;
  assign bus.o_sat      = outSat_q;

endmodule

// File: tb/tb_cal_rii.sv
// Self-checking bench for cal_rii: fixed vectors, busy/back-to-back/reset
// sequences, and random columns against an arithmetic reference model.
module tb_cal_rii;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 i_clk = ~i_clk;

  cal_rii_if bus ();

  cal_rii dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  typedef struct {
    string        name;
    logic [191:0] col;
    logic [19:0]  rii;
    logic         zero;
    logic         sat;
  } vec_t;

  vec_t vecs[6];

  // Reference: exact integer sum of squares, floor sqrt by bisection, clamp.
  function automatic void refModel(input logic [191:0] col, output logic [19:0] rii,
                                   output logic zero, output logic sat);
    longint s = 0;
    longint x, lo, hi, mid;
    logic signed [23:0] e;
    for (int k = 0; k < 8; k++) begin
      e = col[k*24 +: 24];
      x = longint'(e);
      s += x * x;
    end
    lo = 0;
    hi = longint'(1) << 25;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid;
    end
    zero = (s == 0);
    sat  = (s >= (longint'(1) << 38));
    rii  = (lo > 64'h7FFFF) ? 20'h7FFFF : 20'(lo);
  endfunction

  function automatic logic [191:0] randColumn();
    logic [191:0] c;
    logic signed [23:0] e;
    int mode;
    mode = $urandom_range(0, 3);
    c = '0;
    for (int k = 0; k < 8; k++) begin
      e = 24'($urandom);
      case (mode)
        0: e = e >>> $urandom_range(8, 16);
        1: e = e;
        2: e = ($urandom_range(0, 2) == 0) ? (e >>> 4) : 24'sd0;
        default: e = e >>> 6;
      endcase
      c[k*24 +: 24] = e;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits for ready, presents one column, and returns what the result bus shows
  // on the cycle o_div_en rises (lat counts cycles after the accept edge).
  task automatic applyStimulus(input string tag, input logic [191:0] col, output int lat,
                               output logic [19:0] rii, output logic zero, output logic sat,
                               output logic [191:0] hcol);
    int guard;
    @(negedge i_clk);
    guard = 0;
    while (!bus.o_ready && guard < 40) begin
      @(negedge i_clk);
      guard++;
    end
    checkOutput({tag, "_ready_before"}, 192'(bus.o_ready), 192'(1));
    bus.i_valid    = 1'b1;
    bus.i_h_column = col;
    @(posedge i_clk);
    lat = 0;
    do begin
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      lat++;
      if (lat == 1) checkOutput({tag, "_busy_ready"}, 192'(bus.o_ready), 192'(0));
    end while (!bus.o_div_en && lat < 40);
    rii  = bus.o_Rii;
    zero = bus.o_zero;
    sat  = bus.o_sat;
    hcol = bus.o_h_column;
  endtask

  task automatic runAndCheck(input string tag, input logic [191:0] col, input logic [19:0] expRii,
                             input logic expZero, input logic expSat);
    int lat;
    logic [19:0] rii;
    logic zero, sat;
    logic [191:0] hcol;
    applyStimulus(tag, col, lat, rii, zero, sat, hcol);
    checkOutput({tag, "_latency"}, 192'(lat), 192'(29));
    checkOutput({tag, "_rii"}, 192'(rii), 192'(expRii));
    checkOutput({tag, "_zero"}, 192'(zero), 192'(expZero));
    checkOutput({tag, "_sat"}, 192'(sat), 192'(expSat));
    checkOutput({tag, "_hcol"}, hcol, col);
    @(negedge i_clk);
    checkOutput({tag, "_div_en_one_cycle"}, 192'(bus.o_div_en), 192'(0));
    checkOutput({tag, "_ready_after"}, 192'(bus.o_ready), 192'(1));
  endtask

  initial begin
    logic [191:0] colA, colB, colC, satCol;
    logic [19:0]  mRii;
    logic         mZero, mSat;
    int           cyc, seen, divCyc1, divCyc2;
    logic [19:0]  rii1, rii2;
    logic [191:0] hcol1, hcol2;

    satCol = {8{24'h7FFFFF}};
    vecs[0] = '{"unit_re0", 192'h010000, 20'h10000, 1'b0, 1'b0};
    vecs[1] = '{"three_four", {144'h0, 24'h040000, 24'h030000}, 20'h50000, 1'b0, 1'b0};
    vecs[2] = '{"minus_two", {168'h0, 24'hFE0000}, 20'h20000, 1'b0, 1'b0};
    vecs[3] = '{"all_zero", 192'h0, 20'h0, 1'b1, 1'b0};
    vecs[4] = '{"all_max", satCol, 20'h7FFFF, 1'b0, 1'b1};
    vecs[5] = '{"trunc_sqrt8", {144'h0, 24'h000002, 24'hFFFFFE}, 20'h2, 1'b0, 1'b0};

    bus.i_valid    = 1'b0;
    bus.i_h_column = '0;
    i_rst_n        = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_ready", 192'(bus.o_ready), 192'(1));
    checkOutput("reset_div_en", 192'(bus.o_div_en), 192'(0));
    checkOutput("reset_rii", 192'(bus.o_Rii), 192'(0));
    checkOutput("reset_hcol", bus.o_h_column, 192'(0));
    checkOutput("reset_zero", 192'(bus.o_zero), 192'(0));
    checkOutput("reset_sat", 192'(bus.o_sat), 192'(0));
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      runAndCheck(vecs[i].name, vecs[i].col, vecs[i].rii, vecs[i].zero, vecs[i].sat);

    // Valid pulses with a different column while busy must be ignored.
    colA = {24'h000100, 144'h0, 24'h0, 24'h020000};
    colB = {8{24'h123456}};
    @(negedge i_clk);
    bus.i_valid    = 1'b1;
    bus.i_h_column = colA;
    @(posedge i_clk);
    cyc = 0;
    seen = 0;
    divCyc1 = 0;
    rii1 = '0;
    hcol1 = '0;
    while (cyc < 70) begin
      @(negedge i_clk);
      cyc++;
      bus.i_valid    = (cyc == 3 || cyc == 10 || cyc == 20);
      bus.i_h_column = colB;
      if (bus.o_div_en) begin
        seen++;
        if (seen == 1) begin
          divCyc1 = cyc;
          rii1 = bus.o_Rii;
          hcol1 = bus.o_h_column;
        end
      end
    end
    bus.i_valid = 1'b0;
    refModel(colA, mRii, mZero, mSat);
    checkOutput("busy_pulse_div_count", 192'(seen), 192'(1));
    checkOutput("busy_pulse_latency", 192'(divCyc1), 192'(29));
    checkOutput("busy_pulse_rii", 192'(rii1), 192'(mRii));
    checkOutput("busy_pulse_hcol", hcol1, colA);

    // Valid held high: second column accepted exactly 30 cycles after the first.
    colB = {24'h000000, 24'hFFF000, 96'h0, 24'h001000, 24'h050000};
    @(negedge i_clk);
    bus.i_valid    = 1'b1;
    bus.i_h_column = colA;
    @(posedge i_clk);
    cyc = 0;
    seen = 0;
    divCyc2 = 0;
    rii2 = '0;
    hcol2 = '0;
    while (seen < 2 && cyc < 80) begin
      @(negedge i_clk);
      cyc++;
      bus.i_h_column = colB;
      if (bus.o_div_en) begin
        seen++;
        if (seen == 1) begin
          divCyc1 = cyc;
          rii1 = bus.o_Rii;
          hcol1 = bus.o_h_column;
        end else begin
          divCyc2 = cyc;
          rii2 = bus.o_Rii;
          hcol2 = bus.o_h_column;
          bus.i_valid = 1'b0;
        end
      end
    end
    bus.i_valid = 1'b0;
    checkOutput("b2b_div_count", 192'(seen), 192'(2));
    checkOutput("b2b_first_latency", 192'(divCyc1), 192'(29));
    checkOutput("b2b_second_latency", 192'(divCyc2), 192'(59));
    checkOutput("b2b_first_rii", 192'(rii1), 192'(mRii));
    checkOutput("b2b_first_hcol", hcol1, colA);
    refModel(colB, mRii, mZero, mSat);
    checkOutput("b2b_second_rii", 192'(rii2), 192'(mRii));
    checkOutput("b2b_second_hcol", hcol2, colB);

    // Reset in the middle of an operation, right after a saturated result.
    runAndCheck("pre_reset_sat", satCol, 20'h7FFFF, 1'b0, 1'b1);
    colC = {8{24'h00A000}};
    @(negedge i_clk);
    bus.i_valid    = 1'b1;
    bus.i_h_column = colC;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (14) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_div_en", 192'(bus.o_div_en), 192'(0));
    checkOutput("midreset_rii", 192'(bus.o_Rii), 192'(0));
    checkOutput("midreset_hcol", bus.o_h_column, 192'(0));
    checkOutput("midreset_zero", 192'(bus.o_zero), 192'(0));
    checkOutput("midreset_sat", 192'(bus.o_sat), 192'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("midreset_ready_after", 192'(bus.o_ready), 192'(1));
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (bus.o_div_en) seen++;
    end
    checkOutput("midreset_no_div_en", 192'(seen), 192'(0));

    for (int i = 0; i < 24; i++) begin
      colA = randColumn();
      refModel(colA, mRii, mZero, mSat);
      runAndCheck($sformatf("rand%0d", i), colA, mRii, mZero, mSat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
